// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the EX/MEM control bundle.
// Imported by the decode, control and execute stages alike.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int REG_W   = 6;
  localparam int ALUOP_W = 4;

  // Codes 6..15 are unassigned and execute as a zero-result no-op.
  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_NEG   = 4'd3,
    ALU_PASS  = 4'd4,
    ALU_PCADD = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic regwrt;
    logic memtoreg;
    logic pctoreg;
    logic memread;
    logic memwrt;
    logic jumpmem;
  } exmem_ctrl_t;

  // Only the arithmetic ops are allowed to touch the Z/N flags.
  function automatic logic op_sets_flags(input logic [ALUOP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_NEG);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU for the execute stage; wraps silently, no overflow flag.
// flag_we tells the stage whether this op's result should update Z/N.
module alu
  import cpu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic [PC_W-1:0]    PC,
  output logic [DATA_W-1:0]  result,
  output logic               flag_we
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    result = '0;
    unique case (aluop)
      ALU_ADD:   result = rs + rt;
      ALU_SUB:   result = rs - rt;
      ALU_NEG:   result = '0 - rs;
      ALU_PASS:  result = rs;
      ALU_PCADD: result = PC + rt;
      default:   result = '0;
    endcase
  end

  assign flag_we = op_sets_flags(aluop);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, architectural Z/N flags, J/BRZ/BRN resolution with a two-slot
// squash window, and the EX/MEM pipeline register.
module ex_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               regwrt,
  input  logic               memtoreg,
  input  logic               pctoreg,
  input  logic               memread,
  input  logic               memwrt,
  input  logic               jumpmem,
  input  logic               branch_neg,
  input  logic               branch_zero,
  input  logic               jump,
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [PC_W-1:0]    PC,
  output logic               regwrt_out,
  output logic               memtoreg_out,
  output logic               pctoreg_out,
  output logic               memread_out,
  output logic               memwrt_out,
  output logic               jumpmem_out,
  output logic [DATA_W-1:0]  alu_out,
  output logic [DATA_W-1:0]  st_data_out,
  output logic [REG_W-1:0]   rd_out,
  output logic [PC_W-1:0]    PC_out,
  output logic               redirect_out,
  output logic [PC_W-1:0]    target_out,
  output logic               flush_out,
  output logic               z_out,
  output logic               n_out
);

  // Two wrong-path instructions follow any taken redirect.
  localparam logic [1:0] SQ_DEPTH = 2'd2;

  logic [DATA_W-1:0] alu_result;
  logic              alu_flag_we;

  logic              squashing;
  logic              taken;

  exmem_ctrl_t       ctrl_d, ctrl_q;
  logic [DATA_W-1:0] alu_d, alu_q;
  logic [DATA_W-1:0] st_data_d, st_data_q;
  logic [REG_W-1:0]  rd_d, rd_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic              redirect_d, redirect_q;
  logic [PC_W-1:0]   target_d, target_q;
  logic              z_d, z_q;
  logic              n_d, n_q;
  logic [1:0]        sq_d, sq_q;

  alu u_alu (
    .aluop   (aluop),
    .rs      (rs),
    .rt      (rt),
    .PC      (PC),
    .result  (alu_result),
    .flag_we (alu_flag_we)
  );

  // Branch decisions read the flags as they stood before this instruction.
  always_comb begin
    squashing = (sq_q != 2'd0);
    taken     = !squashing && (jump || (branch_zero && z_q) || (branch_neg && n_q));

    ctrl_d = '0;
    if (!squashing) begin
      ctrl_d = '{regwrt:   regwrt,
                 memtoreg: memtoreg,
                 pctoreg:  pctoreg,
                 memread:  memread,
                 memwrt:   memwrt,
                 jumpmem:  jumpmem};
    end

    alu_d      = alu_result;
    st_data_d  = rt;
    rd_d       = rd;
    pc_d       = PC;
    redirect_d = taken;
    target_d   = rs;

    z_d = z_q;
    n_d = n_q;
    if (!squashing && alu_flag_we) begin
      z_d = (alu_result == '0);
      n_d = alu_result[DATA_W-1];
    end

    sq_d = sq_q;
    if (taken)          sq_d = SQ_DEPTH;
    else if (squashing) sq_d = sq_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      alu_q      <= '0;
      st_data_q  <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      sq_q       <= 2'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_q      <= alu_d;
      st_data_q  <= st_data_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      z_q        <= z_d;
      n_q        <= n_d;
      sq_q       <= sq_d;
    end
  end

  assign regwrt_out   = ctrl_q.regwrt;
  assign memtoreg_out = ctrl_q.memtoreg;
  assign pctoreg_out  = ctrl_q.pctoreg;
  assign memread_out  = ctrl_q.memread;
  assign memwrt_out   = ctrl_q.memwrt;
  assign jumpmem_out  = ctrl_q.jumpmem;
  assign alu_out      = alu_q;
  assign st_data_out  = st_data_q;
  assign rd_out       = rd_q;
  assign PC_out       = pc_q;
  assign redirect_out = redirect_q;
  assign target_out   = target_q;
  assign flush_out    = (sq_q != 2'd0);
  assign z_out        = z_q;
  assign n_out        = n_q;

endmodule
